// File: rtl/gpio_bank.sv
// Parametrised GPIO port for the RISC5 I/O space: synchronised inputs, atomic set/clear,
// per-bit edge capture into write-1-to-clear pending bits and a maskable level interrupt.
module gpio_bank #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       wadr,
  input  logic             wr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gp_in,
  output logic [WIDTH-1:0] gp_out,
  output logic [WIDTH-1:0] gp_oe,
  output logic             irq
);

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_OE   = 3'd1;
  localparam logic [2:0] ADR_SET  = 3'd2;
  localparam logic [2:0] ADR_CLR  = 3'd3;
  localparam logic [2:0] ADR_IE   = 3'd4;
  localparam logic [2:0] ADR_RISE = 3'd5;
  localparam logic [2:0] ADR_FALL = 3'd6;
  localparam logic [2:0] ADR_PEND = 3'd7;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] ie_q;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_w;
  logic             we;
  logic             unused_wdata;

  assign we           = sel & wr;
  assign wd           = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      p <= '0;
    end else begin
      sync_q[0] <= gp_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      p <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= RST_OUT;
      oe_q    <= '0;
      ie_q    <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (we) begin
      case (wadr)
        ADR_DATA: out_q   <= wd;
        ADR_OE:   oe_q    <= wd;
        ADR_SET:  out_q   <= out_q | wd;
        ADR_CLR:  out_q   <= out_q & ~wd;
        ADR_IE:   ie_q    <= wd;
        ADR_RISE: rise_en <= wd;
        ADR_FALL: fall_en <= wd;
        default:  ;
      endcase
    end
  end

  // A new event on a bit overrides a clear of that bit in the same cycle.
  assign clr = (we && wadr == ADR_PEND) ? wd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  assign irq    = |(pend & ie_q);
  assign gp_out = out_q;
  assign gp_oe  = oe_q;

  always_comb begin
    rd_w = '0;
    case (wadr)
      ADR_DATA: rd_w = s;
      ADR_OE:   rd_w = oe_q;
      ADR_SET:  rd_w = out_q;
      ADR_CLR:  rd_w = out_q;
      ADR_IE:   rd_w = ie_q;
      ADR_RISE: rd_w = rise_en;
      ADR_FALL: rd_w = fall_en;
      ADR_PEND: rd_w = pend;
      default:  rd_w = '0;
    endcase
    rdata            = '0;
    rdata[WIDTH-1:0] = rd_w;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: default 8-bit build plus a 32-bit/3-stage and a 5-bit build.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wadr;
  logic        wr;
  logic [31:0] wdata;
  logic        sel8, sel32, sel5;

  logic [31:0] rdata8, rdata32, rdata5;
  logic [7:0]  gp_in8, gp_out8, gp_oe8;
  logic [31:0] gp_in32, gp_out32, gp_oe32;
  logic [4:0]  gp_in5, gp_out5, gp_oe5;
  logic        irq8, irq32, irq5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_bank dut8 (
    .clk(clk), .rst(rst), .sel(sel8), .wadr(wadr), .wr(wr), .wdata(wdata),
    .rdata(rdata8), .gp_in(gp_in8), .gp_out(gp_out8), .gp_oe(gp_oe8), .irq(irq8)
  );

  gpio_bank #(.WIDTH(32), .SYNC_STAGES(3)) dut32 (
    .clk(clk), .rst(rst), .sel(sel32), .wadr(wadr), .wr(wr), .wdata(wdata),
    .rdata(rdata32), .gp_in(gp_in32), .gp_out(gp_out32), .gp_oe(gp_oe32), .irq(irq32)
  );

  gpio_bank #(.WIDTH(5), .SYNC_STAGES(2), .RST_OUT(5'h1A)) dut5 (
    .clk(clk), .rst(rst), .sel(sel5), .wadr(wadr), .wr(wr), .wdata(wdata),
    .rdata(rdata5), .gp_in(gp_in5), .gp_out(gp_out5), .gp_oe(gp_oe5), .irq(irq5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input int which, input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    wadr = a;
    #1;
    v = (which == 0) ? rdata8 : (which == 1) ? rdata32 : rdata5;
    check(tag, v, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input int which, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel8  = (which == 0);
    sel32 = (which == 1);
    sel5  = (which == 2);
    wadr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
    sel8  = 1'b0;
    sel32 = 1'b0;
    sel5  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; wadr = 3'd0; wdata = '0;
    sel8 = 1'b0; sel32 = 1'b0; sel5 = 1'b0;
    gp_in8 = 8'($urandom); gp_in32 = $urandom; gp_in5 = 5'($urandom);
    cyc(3);

    // reset state with random pins
    check("rst_gp_out8", 32'(gp_out8), 32'h0);
    check("rst_gp_oe8", 32'(gp_oe8), 32'h0);
    check("rst_irq8", 32'(irq8), 32'h0);
    check("rst_gp_out5", 32'(gp_out5), 32'h1A);
    check("rst_gp_oe32", gp_oe32, 32'h0);
    cyc(1); chk_rd(0, 3'd1, 32'h0, "rst_rd_oe");
    cyc(1); chk_rd(0, 3'd4, 32'h0, "rst_rd_ie");
    cyc(1); chk_rd(0, 3'd5, 32'h0, "rst_rd_rise");
    cyc(1); chk_rd(0, 3'd6, 32'h0, "rst_rd_fall");
    cyc(1); chk_rd(0, 3'd7, 32'h0, "rst_rd_pend");

    gp_in8 = 8'h00; gp_in32 = '0; gp_in5 = '0;
    rst = 1'b1;
    cyc(4);
    chk_rd(0, 3'd7, 32'h0, "settle_pend");
    chk_rd(0, 3'd0, 32'h0, "settle_data");

    // data/oe/set/clr
    wr_reg(0, 3'd0, 32'hFFFF_FFA5);
    check("data_wr", 32'(gp_out8), 32'hA5);
    wr_reg(0, 3'd1, 32'h0000_000F);
    wr_reg(0, 3'd2, 32'h0000_0010);
    check("set_wr", 32'(gp_out8), 32'hB5);
    wr_reg(0, 3'd3, 32'h0000_0001);
    chk_rd(0, 3'd2, 32'hB4, "rd_set");
    chk_rd(0, 3'd3, 32'hB4, "rd_clr");
    chk_rd(0, 3'd1, 32'h0F, "rd_oe");
    check("gp_oe8", 32'(gp_oe8), 32'h0F);

    // write strobe ignored without sel
    @(negedge clk);
    wadr = 3'd0; wdata = 32'hFF; wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    check("nosel_wr", 32'(gp_out8), 32'hB4);

    // rising edge on pin 0 with irq enabled
    wr_reg(0, 3'd5, 32'h01);
    wr_reg(0, 3'd4, 32'h01);
    gp_in8 = 8'h01;
    cyc(1); chk_rd(0, 3'd0, 32'h00, "sync_lat1");
    cyc(1); chk_rd(0, 3'd0, 32'h01, "sync_lat2");
    chk_rd(0, 3'd7, 32'h00, "pend_not_yet");
    check("irq_not_yet", 32'(irq8), 32'h0);
    cyc(1); chk_rd(0, 3'd7, 32'h01, "pend_rise");
    check("irq_rise", 32'(irq8), 32'h1);
    wr_reg(0, 3'd7, 32'h01);
    chk_rd(0, 3'd7, 32'h00, "pend_clr0");
    check("irq_clr0", 32'(irq8), 32'h0);

    // falling-only enable on pin 7; pin 6 rise and disabled events dropped
    wr_reg(0, 3'd5, 32'h00);
    wr_reg(0, 3'd6, 32'h80);
    gp_in8 = 8'h81;
    cyc(4);
    chk_rd(0, 3'd7, 32'h00, "rise_disabled");
    gp_in8 = 8'h41;
    cyc(3);
    chk_rd(0, 3'd7, 32'h80, "pend_fall7");
    check("irq_masked", 32'(irq8), 32'h0);
    wr_reg(0, 3'd4, 32'h80);
    check("irq_ie_on", 32'(irq8), 32'h1);
    wr_reg(0, 3'd4, 32'h00);
    check("irq_ie_off", 32'(irq8), 32'h0);
    wr_reg(0, 3'd4, 32'h80);
    wr_reg(0, 3'd7, 32'h80);
    chk_rd(0, 3'd7, 32'h00, "pend_clr7");
    check("irq_clr7", 32'(irq8), 32'h0);

    // event and clear on same bit in same cycle
    wr_reg(0, 3'd6, 32'h00);
    wr_reg(0, 3'd5, 32'h01);
    wr_reg(0, 3'd4, 32'h01);
    gp_in8 = 8'h40;
    cyc(4);
    gp_in8 = 8'h41;
    cyc(4);
    chk_rd(0, 3'd7, 32'h01, "pend_rise_b");
    check("irq_rise_b", 32'(irq8), 32'h1);
    gp_in8 = 8'h40;
    cyc(4);
    gp_in8 = 8'h41;
    cyc(2);
    sel8 = 1'b1; wadr = 3'd7; wdata = 32'h01; wr = 1'b1;
    cyc(1);
    wr = 1'b0; sel8 = 1'b0;
    chk_rd(0, 3'd7, 32'h01, "evt_beats_clr");
    check("irq_evt_beats_clr", 32'(irq8), 32'h1);
    wr_reg(0, 3'd7, 32'h01);
    chk_rd(0, 3'd7, 32'h00, "pend_clr_b");

    // 32-bit, 3-stage build
    wr_reg(1, 3'd1, 32'hFFFF_FFFF);
    chk_rd(1, 3'd1, 32'hFFFF_FFFF, "oe32");
    gp_in32 = 32'h8000_0001;
    cyc(2); chk_rd(1, 3'd0, 32'h0, "sync32_lat2");
    cyc(1); chk_rd(1, 3'd0, 32'h8000_0001, "sync32_lat3");

    // 5-bit build: upper write bits ignored, upper read bits zero
    wr_reg(2, 3'd0, 32'hFFFF_FFFF);
    chk_rd(2, 3'd2, 32'h0000_001F, "w5_set");
    wr_reg(2, 3'd1, 32'hFFFF_FFFF);
    chk_rd(2, 3'd1, 32'h0000_001F, "w5_oe");
    gp_in5 = 5'h15;
    cyc(3);
    chk_rd(2, 3'd0, 32'h0000_0015, "w5_data");

    // asynchronous reset discards pending state immediately
    gp_in8 = 8'h40;
    cyc(4);
    gp_in8 = 8'h41;
    cyc(4);
    check("irq_before_rst", 32'(irq8), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq8), 32'h0);
    check("async_rst_out", 32'(gp_out8), 32'h0);
    chk_rd(0, 3'd7, 32'h0, "async_rst_pend");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
